spi_mem_master_ctrl: RTL
========================

# spi_mem_master_ctrl

SPI master sequencer for the SPI-slave + single-port RAM wrapper. Turns one host request (byte write or byte read) into the two SPI frames the wrapper needs: an address frame, a minimum SS_n-high gap, then a data frame. It drives SS_n and MOSI, captures MISO, and returns read data on a one-cycle response strobe. It sits between a host-side request/response port and the wrapper's MOSI/MISO/SS_n pins, in the wrapper's clock domain.

## Interface
- `GAP_CYCLES`, default 1: SS_n-high cycles between frames and after the last frame; legal range 1..15.
- `clk` input, 1 bit: single clock; every register updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `req_valid` input, 1 bit: host request present.
- `req_ready` output, 1 bit: controller idle and able to accept a request.
- `req_write` input, 1 bit: 1 = byte write, 0 = byte read.
- `req_addr` input, 8 bits: RAM address.
- `req_wdata` input, 8 bits: write data; ignored for reads.
- `rsp_valid` output, 1 bit: one-cycle completion strobe.
- `rsp_write` output, 1 bit: copy of req_write for the completing operation.
- `rsp_rdata` output, 8 bits: read byte; 0 for writes.
- `SS_n` output, 1 bit: slave select, active-low.
- `MOSI` output, 1 bit: master-out serial data.
- `MISO` input, 1 bit: slave-out serial data.

## Operation
- Reset values:
  - SS_n=1, MOSI=0, rsp_valid=0, rsp_write=0, rsp_rdata=0.
  - req_ready=1, because the FSM resets to IDLE.
- Request handshake:
  - req_ready is 1 only in IDLE.
  - A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - req_addr, req_wdata and req_write are latched at that edge. Later changes to the inputs are ignored.
- Frame format: SS_n is low for exactly 11 cycles; frame cycle index i = 0..10.
  - i=0: mode bit. 1 for write frames, 0 for read frames.
  - i=1: cmd[1].
  - i=2: cmd[0].
  - i=3..10, outgoing frames: payload on MOSI, MSB first.
  - i=3..10, read-data frame: MOSI=0, and MISO is sampled at the rising edge that ends each cycle, MSB first.
- Commands:
  - Write operation: frame cmd 00 with mode 1 and payload = addr, then frame cmd 01 with mode 1 and payload = wdata.
  - Read operation: frame cmd 10 with mode 0 and payload = addr, then frame cmd 11 with mode 0 and read payload.
- FSM states:
  - IDLE -> ADDR on accept.
  - ADDR -> GAP after i=10.
  - GAP -> DATA after GAP_CYCLES.
  - DATA -> TAIL after i=10.
  - TAIL -> IDLE after GAP_CYCLES.
- Response: rsp_valid pulses in the first TAIL cycle, together with rsp_write and rsp_rdata. There is no backpressure on the response.
- Outputs during GAP, TAIL and IDLE: SS_n=1, MOSI=0.
- req_valid during a busy period: it is not accepted, and it stays pending until IDLE.
- Reset mid-operation:
  - SS_n=1 and MOSI=0 from the reset edge onward.
  - The operation is discarded and no rsp_valid is issued.
  - The FSM returns to IDLE.

## Timing
Example below uses GAP_CYCLES=G=1; the accept edge is cycle 0.
- ADDR frame: cycles 1..11.
- GAP: cycle 12.
- DATA frame: cycles 13..23.
- TAIL: cycle 24, with rsp_valid asserted.
- IDLE: cycle 25, req_ready=1.
- General latency, accept to rsp_valid: 23+G cycles.
- General period, accept to next possible accept: 23+2G cycles.
- SS_n and MOSI are registered outputs, with no combinational path from any input.
- A back-to-back request held valid is accepted in the first IDLE cycle.
- Consequently, SS_n always stays high for at least G cycles between frames, including between operations.

## Structure
- Shared package `spi_mem_pkg` holds:
  - Command constants: CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
  - FRAME_LEN=11.
  - The FSM state enum.
- Sub-module `spi_frame_shifter` handles one frame:
  - Inputs: start, mode, cmd, tx_byte.
  - Outputs: SS_n, MOSI, rx_byte, done.
  - Internals: a 4-bit frame counter and an 8-bit shift register.
- The top FSM sequences two shifter frames and the gap/tail counters.

## Test plan
- Write addr=100 (0x64), data=11 (0x0B), G=1:
  - MOSI over cycles 1..11 = 1,0,0,0,1,1,0,0,1,0,0.
  - SS_n=1 at cycle 12.
  - MOSI over cycles 13..23 = 1,0,1,0,0,0,0,1,0,1,1.
  - rsp_valid=1 at cycle 24 with rsp_write=1 and rsp_rdata=0.
- Read addr=100 against a MISO model returning 0x0B:
  - Address frame MOSI = 0,1,0,0,1,1,0,0,1,0,0.
  - Data frame cycles 0..2 = 0,1,1.
  - rsp_rdata=0x0B at cycle 24.
- 100 writes of 11,22,..,253,11,.. to addresses 100..199, followed by 100 reads, with req_valid held high throughout and the wrapper attached:
  - Accepts are spaced exactly 25 cycles apart.
  - Every read returns its reference value.
- req_valid and req_addr change every cycle while busy: latched values are used, and req_ready=0 until IDLE.
- rst_n=0 at cycle 6 of an ADDR frame:
  - SS_n=1 from the next edge.
  - No rsp_valid.
  - req_ready=1 on the first cycle after reset releases.
- GAP_CYCLES=3:
  - SS_n is high for 3 cycles between frames.
  - rsp_valid arrives at cycle 26.
  - The next accept is possible at cycle 29.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory master: wrapper command codes, frame length and FSM states.
package spi_mem_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int         FRAME_LEN  = 11;
   localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP,
      ST_DATA,
      ST_TAIL
   } state_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// One 11-cycle SPI frame: mode bit, 2-bit command, then 8 payload bits MSB first.
// The same shift register serialises tx_byte and collects MISO for read-data frames.
module spi_frame_shifter
   import spi_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mode,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_byte,
   input  logic       MISO,
   output logic       SS_n,
   output logic       MOSI,
   output logic [7:0] rx_byte,
   output logic       done
);

   logic       active;
   logic [3:0] cnt;
   logic [1:0] cmd_r;
   logic [7:0] sr;

   assign done    = active && (cnt == FRAME_LAST);
   // The last MISO bit is taken straight from the pin on the closing edge.
   assign rx_byte = {sr[6:0], MISO};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active <= 1'b0;
         cnt    <= 4'd0;
         SS_n   <= 1'b1;
         MOSI   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= 4'd0;
         SS_n   <= 1'b0;
         MOSI   <= mode;
      end else if (active) begin
         cnt <= cnt + 4'd1;
         if (cnt == FRAME_LAST) begin
            active <= 1'b0;
            SS_n   <= 1'b1;
            MOSI   <= 1'b0;
         end else if (cnt == 4'd0) begin
            MOSI <= cmd_r[1];
         end else if (cnt == 4'd1) begin
            MOSI <= cmd_r[0];
         end else begin
            MOSI <= sr[7];
         end
      end
   end

   // MISO is shifted in from the edge ending cycle 3; the edge ending cycle 2 only drops tx[7].
   always_ff @(posedge clk) begin
      if (start) begin
         cmd_r <= cmd;
         sr    <= tx_byte;
      end else if (active && (cnt >= 4'd2) && (cnt != FRAME_LAST)) begin
         sr <= {sr[6:0], (cnt == 4'd2) ? 1'b0 : MISO};
      end
   end

endmodule

// File: rtl/spi_mem_master_ctrl.sv
// Host request sequencer: turns one byte read/write into address frame, gap, data frame and tail,
// returning read data on a single-cycle response strobe.
module spi_mem_master_ctrl
   import spi_mem_pkg::*;
#(
   parameter int GAP_CYCLES = 1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic       rsp_write,
   output logic [7:0] rsp_rdata,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] gap_cnt;
   logic       gap_done;
   logic       accept;
   logic       op_write;
   logic [7:0] op_wdata;

   logic       frm_start;
   logic       frm_mode;
   logic [1:0] frm_cmd;
   logic [7:0] frm_tx;
   logic [7:0] frm_rx;
   logic       frm_done;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_ready && req_valid;
   assign gap_done  = (gap_cnt == GAP_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Frame launches are decided here so the shifter registers SS_n/MOSI on the same edge.
   always_comb begin
      state_nxt = state;
      frm_start = 1'b0;
      frm_mode  = 1'b0;
      frm_cmd   = CMD_WR_ADDR;
      frm_tx    = 8'h00;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               state_nxt = ST_ADDR;
               frm_start = 1'b1;
               frm_mode  = req_write;
               frm_cmd   = req_write ? CMD_WR_ADDR : CMD_RD_ADDR;
               frm_tx    = req_addr;
            end
         end
         ST_ADDR: begin
            if (frm_done) state_nxt = ST_GAP;
         end
         ST_GAP: begin
            if (gap_done) begin
               state_nxt = ST_DATA;
               frm_start = 1'b1;
               frm_mode  = op_write;
               frm_cmd   = op_write ? CMD_WR_DATA : CMD_RD_DATA;
               frm_tx    = op_write ? op_wdata : 8'h00;
            end
         end
         ST_DATA: begin
            if (frm_done) state_nxt = ST_TAIL;
         end
         ST_TAIL: begin
            if (gap_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_write <= req_write;
         op_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_cnt <= 4'd0;
      end else if (((state == ST_GAP) || (state == ST_TAIL)) && !gap_done) begin
         gap_cnt <= gap_cnt + 4'd1;
      end else begin
         gap_cnt <= 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= 8'h00;
      end else begin
         rsp_valid <= (state == ST_DATA) && frm_done;
         if ((state == ST_DATA) && frm_done) begin
            rsp_write <= op_write;
            rsp_rdata <= op_write ? 8'h00 : frm_rx;
         end
      end
   end

   spi_frame_shifter u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (frm_start),
      .mode    (frm_mode),
      .cmd     (frm_cmd),
      .tx_byte (frm_tx),
      .MISO    (MISO),
      .SS_n    (SS_n),
      .MOSI    (MOSI),
      .rx_byte (frm_rx),
      .done    (frm_done)
   );

endmodule
